// File: rtl/leg_solver_pkg.sv
// ---------------------------------------------------------------------------
// leg_solver_pkg
// Shared definitions for the leg solver: the FSM state encoding, the default
// operand width and the fixed start-to-done latency.
// ---------------------------------------------------------------------------
package leg_solver_pkg;

  // Default operand/result width; squares and their difference use 2*W bits.
  localparam int W_DEF = 8;

  // Edges from the accepting start edge to the edge that raises done.
  localparam int LAT = 2 * W_DEF + 2;

  // Controller states, in the order a computation walks through them.
  typedef enum logic [2:0] {
    IDLE,
    SQ,
    DIFF,
    ROOT,
    FIN
  } state_t;

endpackage

// File: rtl/leg_solver_seq_isqrt_iter.sv
// ---------------------------------------------------------------------------
// isqrt_iter
// Sequential restoring digit-by-digit integer square root. One root bit is
// produced per step, consuming two radicand bits from the MSB end.
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   load      captures radicand and clears root/remainder/step count
//   step      performs one iteration (ignored once done is set)
//   radicand  2W-bit value whose floor square root is wanted
//   root      W-bit partial/final root
//   done      set by the step that completes the W-th iteration
// ---------------------------------------------------------------------------
module isqrt_iter
  import leg_solver_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [2*W-1:0] radicand,
  output logic [W-1:0]   root,
  output logic           done
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] rad;
  logic [W+1:0]   rem;
  logic [CW-1:0]  cnt;
  logic [W+1:0]   rem_sh;
  logic [W+1:0]   trial;

  // The remainder never exceeds 2*root, so shifting it left by two bits and
  // appending the next radicand pair still fits in W+2 bits.
  always_comb begin
    rem_sh = (rem << 2) | (W+2)'(rad[2*W-1 -: 2]);
    trial  = {root, 2'b01};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad  <= '0;
      rem  <= '0;
      root <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (load) begin
      rad  <= radicand;
      rem  <= '0;
      root <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (step && !done) begin
      // Keep the trial subtraction only when the remainder stays non-negative.
      if (rem_sh >= trial) begin
        rem  <= rem_sh - trial;
        root <= {root[W-2:0], 1'b1};
      end else begin
        rem  <= rem_sh;
        root <= {root[W-2:0], 1'b0};
      end
      rad  <= rad << 2;
      cnt  <= cnt + 1'b1;
      done <= (cnt == CW'(W - 1));
    end
  end

endmodule

// File: rtl/leg_solver_seq.sv
// ---------------------------------------------------------------------------
// leg_solver_seq
// Multicycle inverse of the magnitude unit: y = floor(sqrt(r^2 - x^2)).
// W cycles of parallel shift-add squaring, one difference cycle, W cycles of
// restoring square root, one finish cycle. Latency is 2W+2 enabled edges.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   ena         clock qualifier; when low all state and outputs hold
//   start       request, accepted in IDLE on an enabled edge
//   r_in, x_in  hypotenuse and known leg, latched on acceptance
//   busy        high while a computation is in flight
//   done        one enabled-cycle pulse when y_out/err update
//   y_out       result leg, held until the next done
//   err         set with done when x > r (y_out is then 0)
// ---------------------------------------------------------------------------
module leg_solver_seq
  import leg_solver_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         start,
  input  logic [W-1:0] r_in,
  input  logic [W-1:0] x_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] y_out,
  output logic         err
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t         state;
  logic [W-1:0]   r_reg;
  logic [W-1:0]   x_reg;
  logic [2*W-1:0] r_sq;
  logic [2*W-1:0] x_sq;
  logic [CW-1:0]  bit_cnt;
  logic           err_int;

  logic [2*W-1:0] r_pp;
  logic [2*W-1:0] x_pp;
  logic [2*W-1:0] diff_next;
  logic           sqrt_load;
  logic           sqrt_step;
  logic [W-1:0]   sqrt_root;
  logic           sqrt_done;

  // Partial products for the current multiplier bit (LSB first), and the
  // clamped difference handed to the root unit in the DIFF cycle.
  always_comb begin
    r_pp      = r_reg[bit_cnt] ? ({{W{1'b0}}, r_reg} << bit_cnt) : '0;
    x_pp      = x_reg[bit_cnt] ? ({{W{1'b0}}, x_reg} << bit_cnt) : '0;
    diff_next = (x_reg > r_reg) ? '0 : (r_sq - x_sq);
    sqrt_load = ena && (state == DIFF);
    sqrt_step = ena && (state == ROOT);
  end

  isqrt_iter #(.W(W)) u_isqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sqrt_load),
    .step     (sqrt_step),
    .radicand (diff_next),
    .root     (sqrt_root),
    .done     (sqrt_done)
  );

  // Controller and squaring datapath. Everything advances only on enabled
  // edges, so a pending done pulse simply stretches while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      r_reg   <= '0;
      x_reg   <= '0;
      r_sq    <= '0;
      x_sq    <= '0;
      bit_cnt <= '0;
      err_int <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      y_out   <= '0;
      err     <= 1'b0;
    end else if (ena) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            r_reg   <= r_in;
            x_reg   <= x_in;
            r_sq    <= '0;
            x_sq    <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= SQ;
          end
        end
        SQ: begin
          r_sq <= r_sq + r_pp;
          x_sq <= x_sq + x_pp;
          if (bit_cnt == CW'(W - 1)) begin
            bit_cnt <= '0;
            state   <= DIFF;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DIFF: begin
          err_int <= (x_reg > r_reg);
          state   <= ROOT;
        end
        ROOT: begin
          if (bit_cnt == CW'(W - 1)) begin
            bit_cnt <= '0;
            state   <= FIN;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        FIN: begin
          y_out <= sqrt_root;
          err   <= err_int;
          done  <= sqrt_done;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leg_solver_seq.sv
// ---------------------------------------------------------------------------
// tb_leg_solver_seq
// Directed self-checking bench for leg_solver_seq with hand-computed results.
// ---------------------------------------------------------------------------
module tb_leg_solver_seq;
  import leg_solver_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic [7:0] r_in;
  logic [7:0] x_in;
  logic       busy;
  logic       done;
  logic [7:0] y_out;
  logic       err;

  int tests_run;
  int tests_failed;

  leg_solver_seq #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (start),
    .r_in  (r_in),
    .x_in  (x_in),
    .busy  (busy),
    .done  (done),
    .y_out (y_out),
    .err   (err)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start so that it is sampled on exactly one edge (E0); returns #1
  // after E0.
  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] x);
    @(negedge clk);
    r_in  = r;
    x_in  = x;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for done, counting edges after E0, bounded by max_edges.
  task automatic waitDone(input int max_edges, output int edge_no, output bit seen);
    seen    = 1'b0;
    edge_no = 0;
    for (int e = 1; e <= max_edges; e++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        seen    = 1'b1;
        edge_no = e;
        break;
      end
    end
  endtask

  // Reset state of all outputs.
  task automatic test_reset();
    rst_n = 1'b0;
    ena   = 1'b1;
    start = 1'b0;
    r_in  = '0;
    x_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done got %b exp 0", done); end
    tests_run++;
    if (y_out !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_y got %0d exp 0", y_out); end
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err got %b exp 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Exact cycle timing of busy/done for r=5, x=3 (y=4).
  task automatic test_latency();
    bit early_done;
    early_done = 1'b0;
    applyStimulus(8'd5, 8'd3);
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL lat_busy_e1 got %b exp 1", busy); end
      end
      if (e < LAT && done !== 1'b0) early_done = 1'b1;
    end
    tests_run++;
    if (early_done) begin tests_failed++; $display("[TB] FAIL lat_early_done got 1 exp 0"); end
    tests_run++;
    if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL lat_done_e18 got %b exp 1", done); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL lat_busy_e18 got %b exp 0", busy); end
    tests_run++;
    if (y_out !== 8'd4) begin tests_failed++; $display("[TB] FAIL lat_y got %0d exp 4", y_out); end
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL lat_err got %b exp 0", err); end
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL lat_done_pulse got %b exp 0", done); end
  endtask

  // Valid (non-error) vectors including x=0 and a large difference.
  task automatic test_values();
    logic [7:0] rv [4];
    logic [7:0] xv [4];
    logic [7:0] yv [4];
    int  edge_no;
    bit  seen;
    rv = '{8'd255, 8'd10, 8'd0, 8'd255};
    xv = '{8'd0,   8'd7,  8'd0, 8'd254};
    yv = '{8'd255, 8'd7,  8'd0, 8'd22};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(rv[i], xv[i]);
      waitDone(LAT + 10, edge_no, seen);
      tests_run++;
      if (!seen || edge_no != LAT) begin
        tests_failed++;
        $display("[TB] FAIL val%0d_done_edge got %0d (seen %b) exp %0d", i, edge_no, seen, LAT);
      end
      tests_run++;
      if (y_out !== yv[i] || err !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL val%0d_y r=%0d x=%0d got y=%0d err=%b exp y=%0d err=0",
                 i, rv[i], xv[i], y_out, err, yv[i]);
      end
    end
  endtask

  // x > r raises err; a following x = r clears it.
  task automatic test_err();
    logic [7:0] rv [2];
    logic [7:0] xv [2];
    logic       ev [2];
    int  edge_no;
    bit  seen;
    rv = '{8'd3, 8'd200};
    xv = '{8'd5, 8'd200};
    ev = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      applyStimulus(rv[i], xv[i]);
      waitDone(LAT + 10, edge_no, seen);
      tests_run++;
      if (!seen || edge_no != LAT) begin
        tests_failed++;
        $display("[TB] FAIL err%0d_done_edge got %0d (seen %b) exp %0d", i, edge_no, seen, LAT);
      end
      tests_run++;
      if (y_out !== 8'd0 || err !== ev[i]) begin
        tests_failed++;
        $display("[TB] FAIL err%0d_result got y=%0d err=%b exp y=0 err=%b", i, y_out, err, ev[i]);
      end
    end
  endtask

  // A start pulse while busy must be ignored (r=20, x=12 -> 16).
  task automatic test_back_to_back();
    int pulses;
    int done_edge;
    pulses    = 0;
    done_edge = 0;
    applyStimulus(8'd20, 8'd12);
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) start = 1'b0;
      if (done === 1'b1) begin
        pulses++;
        if (done_edge == 0) done_edge = e;
      end
      if (e == 4) begin
        r_in  = 8'd9;
        x_in  = 8'd0;
        start = 1'b1;
      end
    end
    tests_run++;
    if (pulses != 1 || done_edge != LAT) begin
      tests_failed++;
      $display("[TB] FAIL busy_start_pulses got %0d at edge %0d exp 1 at edge %0d", pulses, done_edge, LAT);
    end
    tests_run++;
    if (y_out !== 8'd16 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL busy_start_result got y=%0d err=%b exp y=16 err=0", y_out, err);
    end
  endtask

  // ena low for 5 edges during ROOT stretches latency to 23 (r=17, x=8 -> 15).
  task automatic test_ena();
    int         done_edge;
    bit         unstable;
    logic [7:0] y_snap;
    logic       err_snap;
    done_edge = 0;
    unstable  = 1'b0;
    y_snap    = '0;
    err_snap  = 1'b0;
    applyStimulus(8'd17, 8'd8);
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (e >= 12 && e <= 16) begin
        if (busy !== 1'b1 || done !== 1'b0 || y_out !== y_snap || err !== err_snap) unstable = 1'b1;
      end
      if (done === 1'b1 && done_edge == 0) done_edge = e;
      if (e == 11) begin
        y_snap   = y_out;
        err_snap = err;
        ena      = 1'b0;
      end
      if (e == 16) ena = 1'b1;
      if (done_edge != 0) break;
    end
    ena = 1'b1;
    tests_run++;
    if (unstable) begin tests_failed++; $display("[TB] FAIL ena_hold outputs moved got 1 exp 0"); end
    tests_run++;
    if (done_edge != LAT + 5) begin
      tests_failed++;
      $display("[TB] FAIL ena_done_edge got %0d exp %0d", done_edge, LAT + 5);
    end
    tests_run++;
    if (y_out !== 8'd15 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ena_result got y=%0d err=%b exp y=15 err=0", y_out, err);
    end
  endtask

  // Asynchronous reset mid-SQ aborts; a fresh start afterwards works.
  task automatic test_reset_mid();
    int edge_no;
    bit seen;
    applyStimulus(8'd100, 8'd60);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || y_out !== 8'd0 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_outputs got busy=%b done=%b y=%0d err=%b exp all 0", busy, done, y_out, err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitDone(25, edge_no, seen);
    tests_run++;
    if (seen) begin tests_failed++; $display("[TB] FAIL rst_mid_no_done got done at %0d exp none", edge_no); end
    applyStimulus(8'd13, 8'd12);
    waitDone(LAT + 10, edge_no, seen);
    tests_run++;
    if (!seen || edge_no != LAT) begin
      tests_failed++;
      $display("[TB] FAIL rst_restart_edge got %0d (seen %b) exp %0d", edge_no, seen, LAT);
    end
    tests_run++;
    if (y_out !== 8'd5 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_restart_result got y=%0d err=%b exp y=5 err=0", y_out, err);
    end
  endtask

  // Scenario sequence.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_latency();
    test_values();
    test_err();
    test_back_to_back();
    test_ena();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
